// File: rtl/taxi_axis_cobs_decode_ext.sv
// COBS byte-stream decoder with XOR delimiter, optional length cap and saturating frame stats.
// Each decoded byte is held one step so tlast can ride on the final byte of a frame.
module taxi_axis_cobs_decode_ext #(
  parameter logic [7:0]  DELIM   = 8'h00,
  parameter int unsigned MAX_LEN = 0,
  parameter int unsigned STAT_W  = 16,
  parameter bit          LAST_EN = 1'b1,
  parameter bit          USER_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        s_axis_tdata_i,
  input  logic              s_axis_tvalid_i,
  output logic              s_axis_tready_o,
  input  logic              s_axis_tlast_i,
  input  logic              s_axis_tuser_i,
  output logic [7:0]        m_axis_tdata_o,
  output logic              m_axis_tkeep_o,
  output logic              m_axis_tstrb_o,
  output logic              m_axis_tvalid_o,
  input  logic              m_axis_tready_i,
  output logic              m_axis_tlast_o,
  output logic              m_axis_tid_o,
  output logic              m_axis_tdest_o,
  output logic              m_axis_tuser_o,
  output logic [STAT_W-1:0] stat_frames_o,
  output logic [STAT_W-1:0] stat_errors_o,
  output logic              err_framing_o,
  output logic              err_overflow_o
);

  localparam int unsigned LenW = $clog2(MAX_LEN + 2);

  typedef enum logic [1:0] {StIdle, StSeg, StNext, StDrop} state_e;

  state_e              state_q, state_d;
  logic [7:0]          count_q, count_d;
  logic                sup_q, sup_d;
  logic [7:0]          hold_q, hold_d;
  logic                hold_vld_q, hold_vld_d;
  logic [LenW-1:0]     len_q, len_d;
  logic                s_tready_q, s_tready_d;
  logic [9:0]          mem_q [2];
  logic                wr_ptr_q, rd_ptr_q;
  logic [1:0]          fcnt_q, fcnt_d;
  logic [STAT_W-1:0]   stat_frames_q, stat_frames_d;
  logic [STAT_W-1:0]   stat_errors_q, stat_errors_d;
  logic                err_framing_q, err_overflow_q;

  logic       in_hs, last_in, user_in, pop;
  logic [7:0] b;
  logic       push, push_last, push_user;
  logic [7:0] push_data;
  logic       data_en, frame_err, ovf, err_to_idle;
  logic [7:0] data_val;

  assign b       = s_axis_tdata_i ^ DELIM;
  assign in_hs   = s_axis_tvalid_i && s_tready_q;
  assign last_in = LAST_EN && s_axis_tlast_i;
  assign user_in = USER_EN && s_axis_tuser_i;
  assign pop     = (fcnt_q != 2'd0) && m_axis_tready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    sup_d       = sup_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    len_d       = len_q;
    push        = 1'b0;
    push_last   = 1'b0;
    push_user   = 1'b0;
    push_data   = hold_q;
    data_en     = 1'b0;
    data_val    = b;
    frame_err   = 1'b0;
    ovf         = 1'b0;
    err_to_idle = 1'b0;

    unique case (state_q)
      StIdle: begin
        len_d = '0;
        // Final byte of the previous frame leaves here, once the skid buffer has room.
        if (hold_vld_q && fcnt_q != 2'd2) begin
          push       = 1'b1;
          push_last  = 1'b1;
          hold_vld_d = 1'b0;
        end
        if (in_hs && b != 8'h00) begin
          count_d = b - 8'd1;
          sup_d   = (b == 8'hFF);
          state_d = (b == 8'h01) ? StNext : StSeg;
        end
      end
      StSeg: begin
        if (in_hs) begin
          if (b == 8'h00 || (last_in && (count_q != 8'd1 || user_in))) begin
            frame_err   = 1'b1;
            err_to_idle = 1'b1;
          end else begin
            data_en = 1'b1;
            count_d = count_q - 8'd1;
            if (last_in) begin
              state_d = StIdle;
            end else if (count_q == 8'd1) begin
              state_d = StNext;
            end
          end
        end
      end
      StNext: begin
        if (in_hs) begin
          if (b == 8'h00) begin
            if (user_in) begin
              frame_err   = 1'b1;
              err_to_idle = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end else if (last_in) begin
            if (b == 8'h01 && !user_in) begin
              state_d = StIdle;
            end else begin
              frame_err   = 1'b1;
              err_to_idle = 1'b1;
            end
          end else begin
            data_en  = !sup_q;
            data_val = 8'h00;
            count_d  = b - 8'd1;
            sup_d    = (b == 8'hFF);
            state_d  = (b == 8'h01) ? StNext : StSeg;
          end
        end
      end
      StDrop: begin
        if (in_hs && (b == 8'h00 || last_in)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (data_en) begin
      if (MAX_LEN != 0 && len_q == LenW'(MAX_LEN)) begin
        ovf = 1'b1;
      end else begin
        if (hold_vld_q) begin
          push = 1'b1;
        end
        hold_d     = data_val;
        hold_vld_d = 1'b1;
        if (MAX_LEN != 0) begin
          len_d = len_q + LenW'(1);
        end
      end
    end

    if (frame_err || ovf) begin
      push       = 1'b1;
      push_last  = 1'b1;
      push_user  = 1'b1;
      push_data  = hold_vld_q ? hold_q : 8'h00;
      hold_vld_d = 1'b0;
      state_d    = (err_to_idle || (ovf && last_in)) ? StIdle : StDrop;
    end
  end

  always_comb begin
    fcnt_d        = fcnt_q + 2'(push) - 2'(pop);
    // At most one push per accepted byte, so one free slot is enough to take the next input.
    s_tready_d    = (state_d == StDrop) || (fcnt_d != 2'd2);
    stat_frames_d = stat_frames_q;
    stat_errors_d = stat_errors_q;
    if (push && push_last && !push_user && stat_frames_q != '1) begin
      stat_frames_d = stat_frames_q + STAT_W'(1);
    end
    if ((frame_err || ovf) && stat_errors_q != '1) begin
      stat_errors_d = stat_errors_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q        <= '0;
      sup_q          <= 1'b0;
      hold_q         <= '0;
      hold_vld_q     <= 1'b0;
      len_q          <= '0;
      s_tready_q     <= 1'b0;
      mem_q[0]       <= '0;
      mem_q[1]       <= '0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      fcnt_q         <= '0;
      stat_frames_q  <= '0;
      stat_errors_q  <= '0;
      err_framing_q  <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      count_q        <= count_d;
      sup_q          <= sup_d;
      hold_q         <= hold_d;
      hold_vld_q     <= hold_vld_d;
      len_q          <= len_d;
      s_tready_q     <= s_tready_d;
      fcnt_q         <= fcnt_d;
      stat_frames_q  <= stat_frames_d;
      stat_errors_q  <= stat_errors_d;
      err_framing_q  <= frame_err;
      err_overflow_q <= ovf;
      if (push) begin
        mem_q[wr_ptr_q] <= {push_user, push_last, push_data};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  always_comb begin
    s_axis_tready_o = s_tready_q;
    m_axis_tvalid_o = (fcnt_q != 2'd0);
    {m_axis_tuser_o, m_axis_tlast_o, m_axis_tdata_o} = mem_q[rd_ptr_q];
    m_axis_tkeep_o  = 1'b1;
    m_axis_tstrb_o  = 1'b1;
    m_axis_tid_o    = 1'b0;
    m_axis_tdest_o  = 1'b0;
    stat_frames_o   = stat_frames_q;
    stat_errors_o   = stat_errors_q;
    err_framing_o   = err_framing_q;
    err_overflow_o  = err_overflow_q;
  end

endmodule

// File: tb/tb_taxi_axis_cobs_decode_ext.sv
// Directed and randomised checks of the COBS decoder in three configurations:
// default, DELIM=8'hA5, and MAX_LEN=4.
module tb_taxi_axis_cobs_decode_ext;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  s_tdata [3];
  logic        s_tvalid [3];
  logic        s_tready [3];
  logic        s_tlast [3];
  logic        s_tuser [3];
  logic [7:0]  m_tdata [3];
  logic        m_tkeep [3];
  logic        m_tstrb [3];
  logic        m_tvalid [3];
  logic        m_tready [3];
  logic        m_tlast [3];
  logic        m_tid [3];
  logic        m_tdest [3];
  logic        m_tuser [3];
  logic [15:0] st_frm [3];
  logic [15:0] st_err [3];
  logic        e_frm [3];
  logic        e_ovf [3];

  int n_checks = 0;
  int n_errs = 0;
  int frm_cnt [3] = '{0, 0, 0};
  int ovf_cnt [3] = '{0, 0, 0};
  bit rand_rdy = 1'b0;
  bit hold_rdy = 1'b0;

  logic [9:0] q0 [$];
  logic [9:0] q1 [$];
  logic [9:0] q2 [$];
  logic [7:0] dq [$];
  logic [7:0] enc [$];
  logic [9:0] expq [$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam logic [7:0]  D  = (g == 1) ? 8'hA5 : 8'h00;
    localparam int unsigned ML = (g == 2) ? 4 : 0;
    taxi_axis_cobs_decode_ext #(.DELIM(D), .MAX_LEN(ML), .STAT_W(16)) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .s_axis_tdata_i (s_tdata[g]),
      .s_axis_tvalid_i(s_tvalid[g]),
      .s_axis_tready_o(s_tready[g]),
      .s_axis_tlast_i (s_tlast[g]),
      .s_axis_tuser_i (s_tuser[g]),
      .m_axis_tdata_o (m_tdata[g]),
      .m_axis_tkeep_o (m_tkeep[g]),
      .m_axis_tstrb_o (m_tstrb[g]),
      .m_axis_tvalid_o(m_tvalid[g]),
      .m_axis_tready_i(m_tready[g]),
      .m_axis_tlast_o (m_tlast[g]),
      .m_axis_tid_o   (m_tid[g]),
      .m_axis_tdest_o (m_tdest[g]),
      .m_axis_tuser_o (m_tuser[g]),
      .stat_frames_o  (st_frm[g]),
      .stat_errors_o  (st_err[g]),
      .err_framing_o  (e_frm[g]),
      .err_overflow_o (e_ovf[g])
    );
  end

  // Inputs settle 1 time unit after posedge, so the negedge view matches the next handshake.
  always @(negedge clk) begin
    if (m_tvalid[0] && m_tready[0]) q0.push_back({m_tuser[0], m_tlast[0], m_tdata[0]});
    if (m_tvalid[1] && m_tready[1]) q1.push_back({m_tuser[1], m_tlast[1], m_tdata[1]});
    if (m_tvalid[2] && m_tready[2]) q2.push_back({m_tuser[2], m_tlast[2], m_tdata[2]});
    for (int i = 0; i < 3; i++) begin
      if (e_frm[i]) frm_cnt[i]++;
      if (e_ovf[i]) ovf_cnt[i]++;
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) m_tready[i] = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        m_tready[i] = hold_rdy ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int qsize(input int sel);
    case (sel)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [9:0] qpop(input int sel);
    case (sel)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic put(input int sel, input logic [7:0] d);
    bit hs = 1'b0;
    int n = 0;
    s_tdata[sel]  = d;
    s_tvalid[sel] = 1'b1;
    while (!hs && n < 400) begin
      @(negedge clk);
      hs = s_tready[sel];
      @(posedge clk);
      #1;
      n++;
    end
    s_tvalid[sel] = 1'b0;
    if (!hs) check_eq("put_timeout", 32'(hs), 1);
  endtask

  task automatic send(input int sel, input int n, input logic [127:0] vec);
    for (int i = 0; i < n; i++) put(sel, vec[8*(n-1-i) +: 8]);
  endtask

  task automatic expect_beat(input int sel, input string tag, input logic [9:0] exp);
    int n = 0;
    while (qsize(sel) == 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (qsize(sel) == 0) check_eq({tag, "_missing"}, 32'(qsize(sel)), 1);
    else check_eq(tag, 32'(qpop(sel)), 32'(exp));
  endtask

  // Beats are {tuser, tlast, tdata}; only the final beat carries tlast (and u as tuser).
  task automatic expect_seq(input int sel, input string tag, input int n, input logic [127:0] vec,
                            input logic u);
    for (int i = 0; i < n; i++) begin
      expect_beat(sel, tag, {u && (i == n - 1), (i == n - 1), vec[8*(n-1-i) +: 8]});
    end
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Reference COBS encoder over dq into enc (delimiter 0).
  task automatic encode_frame();
    logic [7:0] blk [$];
    logic [7:0] code = 8'd1;
    enc.delete();
    foreach (dq[i]) begin
      if (dq[i] == 8'h00) begin
        enc.push_back(code);
        foreach (blk[j]) enc.push_back(blk[j]);
        blk.delete();
        code = 8'd1;
      end else begin
        blk.push_back(dq[i]);
        code++;
        if (code == 8'hFF) begin
          enc.push_back(code);
          foreach (blk[j]) enc.push_back(blk[j]);
          blk.delete();
          code = 8'd1;
        end
      end
    end
    enc.push_back(code);
    foreach (blk[j]) enc.push_back(blk[j]);
    enc.push_back(8'h00);
  endtask

  initial begin
    int r_frames = 0;
    int len;
    int n;
    for (int i = 0; i < 3; i++) begin
      s_tdata[i]  = 8'h00;
      s_tvalid[i] = 1'b0;
      s_tlast[i]  = 1'b0;
      s_tuser[i]  = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq("reset_tready", 32'(s_tready[i]), 0);
      check_eq("reset_tvalid", 32'(m_tvalid[i]), 0);
      check_eq("reset_frames", 32'(st_frm[i]), 0);
      check_eq("reset_errors", 32'(st_err[i]), 0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("tready_rise", 32'(s_tready[0]), 1);

    // Basic decode with an embedded zero.
    send(0, 6, 128'h03_11_22_02_33_00);
    expect_seq(0, "t1_beat", 4, 128'h11_22_00_33, 1'b0);
    settle();
    check_eq("t1_frames", 32'(st_frm[0]), 1);

    // 0xFF code: 254 data bytes with no implied zero, then a further segment.
    put(0, 8'hFF);
    for (int i = 1; i <= 254; i++) put(0, 8'(i));
    send(0, 3, 128'h02_33_00);
    for (int i = 1; i <= 254; i++) expect_beat(0, "t2_data", {2'b00, 8'(i)});
    expect_beat(0, "t2_end", {2'b01, 8'h33});
    settle();
    check_eq("t2_frames", 32'(st_frm[0]), 2);

    // Empty frame produces nothing.
    send(0, 2, 128'h01_00);
    repeat (10) @(posedge clk);
    #1;
    check_eq("empty_nobeat", 32'(qsize(0)), 0);
    check_eq("empty_frames", 32'(st_frm[0]), 2);

    // Delimiter mid-segment.
    send(0, 4, 128'h04_11_22_00);
    expect_seq(0, "t4_err", 2, 128'h11_22, 1'b1);
    settle();
    check_eq("t4_framing_pulses", 32'(frm_cnt[0]), 1);
    check_eq("t4_errors", 32'(st_err[0]), 1);
    check_eq("t4_frames", 32'(st_frm[0]), 2);
    send(0, 3, 128'h02_44_00);
    expect_seq(0, "t4_next", 1, 128'h44, 1'b0);
    settle();
    check_eq("t4_frames_after", 32'(st_frm[0]), 3);

    // Non-zero delimiter; raw 0x00 is data and decodes to 0xA5.
    send(1, 4, 128'hA6_B4_87_A5);
    expect_seq(1, "t3_a5", 2, 128'h11_22, 1'b0);
    send(1, 3, 128'hA7_00_A5);
    expect_seq(1, "t3_raw00", 1, 128'hA5, 1'b0);
    settle();
    check_eq("t3_frames", 32'(st_frm[1]), 2);
    check_eq("t3_no_framing", 32'(frm_cnt[1]), 0);

    // Length cap of 4: fifth byte truncates the frame.
    send(2, 7, 128'h06_01_02_03_04_05_00);
    expect_seq(2, "t5_ovf", 4, 128'h01_02_03_04, 1'b1);
    settle();
    check_eq("t5_no_extra", 32'(qsize(2)), 0);
    check_eq("t5_ovf_pulses", 32'(ovf_cnt[2]), 1);
    check_eq("t5_errors", 32'(st_err[2]), 1);
    send(2, 3, 128'h02_55_00);
    expect_seq(2, "t5_next", 1, 128'h55, 1'b0);
    settle();
    check_eq("t5_frames", 32'(st_frm[2]), 1);

    // Random frames against the reference encoder with a 50% sink.
    rand_rdy = 1'b1;
    expq.delete();
    for (int f = 0; f < 1000; f++) begin
      len = ($urandom_range(0, 49) == 0) ? int'($urandom_range(255, 300))
                                         : int'($urandom_range(0, 16));
      dq.delete();
      for (int i = 0; i < len; i++) begin
        dq.push_back(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
      end
      for (int i = 0; i < len; i++) expq.push_back({1'b0, (i == len - 1), dq[i]});
      if (len != 0) r_frames++;
      encode_frame();
      foreach (enc[i]) put(0, enc[i]);
    end
    n = 0;
    while (q0.size() < expq.size() && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    settle();
    check_eq("rand_count", 32'(q0.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size() && i < q0.size(); i++) begin
      check_eq("rand_beat", 32'(q0[i]), 32'(expq[i]));
    end
    check_eq("rand_frames", 32'(st_frm[0]), 32'(3 + r_frames));
    check_eq("rand_no_framing", 32'(frm_cnt[0]), 1);
    q0.delete();
    rand_rdy = 1'b0;

    // Reset in the middle of a frame with beats pending.
    hold_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    send(0, 3, 128'h05_11_22);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_pre_valid", 32'(m_tvalid[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_tvalid", 32'(m_tvalid[0]), 0);
    check_eq("rst_tready", 32'(s_tready[0]), 0);
    check_eq("rst_frames", 32'(st_frm[0]), 0);
    @(negedge clk) rst_n = 1'b1;
    hold_rdy = 1'b0;
    @(posedge clk);
    #1;
    send(0, 3, 128'h02_44_00);
    expect_seq(0, "rst_next", 1, 128'h44, 1'b0);
    settle();
    check_eq("rst_no_stale", 32'(qsize(0)), 0);
    check_eq("rst_frames_after", 32'(st_frm[0]), 1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
